// File: rtl/paddle_pos_capture.sv
// paddle_pos_capture: measures how many scanlines the paddle comparator stays
// high after the pad enable window opens, and publishes that count as an 8-bit
// position with a one-cycle valid strobe.
// Optional feature macro: PADCAP_FILTER_EN. When it is defined, a fall of
// pad_out must persist for FILTER_LEN samples before it is accepted.
module paddle_pos_capture #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       pad_en_n,
  input  logic       pad_out,
  output logic [7:0] pos,
  output logic       pos_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;

  state_t     state_q, state_d;
  logic       hsync_q, hsync_prev_q, pad_en_n_q, pad_out_q;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pos_q, pos_d;
  logic       pos_valid_q, pos_valid_d;
  logic       timeout_q, timeout_d;
  logic       busy_q, busy_d;

  logic       tick;
  logic       fall_ok;
  logic [7:0] fall_val, close_val;

  assign tick = hsync_q & ~hsync_prev_q;

`ifdef PADCAP_FILTER_EN
  logic [3:0] run_q, run_d;
  logic [7:0] first_q, first_d;

  // Debounce the fall: count consecutive low samples, remember cnt at the first one
  always_comb begin
    run_d     = 4'd0;
    first_d   = first_q;
    fall_ok   = 1'b0;
    fall_val  = cnt_q;
    close_val = cnt_q;
    if (state_q == MEAS && !pad_out_q) begin
      run_d     = (run_q == 4'hF) ? run_q : run_q + 4'd1;
      if (run_q == 4'd0) first_d = cnt_q;
      fall_val  = (run_q == 4'd0) ? cnt_q : first_q;
      close_val = fall_val;
      fall_ok   = ({1'b0, run_q} + 5'd1) >= 5'(FILTER_LEN);
    end
  end
`else
  logic filt_len_unused;
  assign filt_len_unused = (FILTER_LEN > 0);

  // Without the filter a single low sample is a fall
  always_comb begin
    fall_ok   = ~pad_out_q;
    fall_val  = cnt_q;
    close_val = cnt_q;
  end
`endif

  // Measurement FSM: next state, line counter and capture outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    timeout_d   = timeout_q;
    pos_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pad_en_n_q) begin
          state_d = MEAS;
          cnt_d   = 8'd0;
        end
      end
      MEAS: begin
        if (fall_ok) begin
          pos_d       = fall_val;
          timeout_d   = 1'b0;
          pos_valid_d = 1'b1;
          state_d     = DONE;
        end else if (!pad_en_n_q) begin
          pos_d       = close_val;
          timeout_d   = 1'b1;
          pos_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (tick) begin
          if (cnt_q == 8'hFF) begin
            pos_d       = 8'hFF;
            timeout_d   = 1'b1;
            pos_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DONE: begin
        if (!pad_en_n_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MEAS);
  end

  // All state, input registers and registered outputs
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hsync_q      <= 1'b0;
      hsync_prev_q <= 1'b0;
      pad_en_n_q   <= 1'b0;
      pad_out_q    <= 1'b0;
      cnt_q        <= 8'd0;
      pos_q        <= 8'd0;
      pos_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PADCAP_FILTER_EN
      run_q        <= 4'd0;
      first_q      <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      hsync_q      <= hsync;
      hsync_prev_q <= hsync_q;
      pad_en_n_q   <= pad_en_n;
      pad_out_q    <= pad_out;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
`ifdef PADCAP_FILTER_EN
      run_q        <= run_d;
      first_q      <= first_d;
`endif
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_paddle_pos_capture.sv
// Bench for paddle_pos_capture: directed windows driven by a paddle generator
// model or a manual pad_out pattern; a line-level model predicts every output.
module tb_paddle_pos_capture;
  localparam int FLEN = 4;
`ifdef PADCAP_FILTER_EN
  localparam int ACC = FLEN;
`else
  localparam int ACC = 1;
`endif

  logic       clk_sys = 0, reset_n = 0, hsync = 0, pad_en_n = 0, pad_out = 1;
  logic [7:0] pos;
  logic       pos_valid, timeout, busy;

  paddle_pos_capture #(.FILTER_LEN(FLEN)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .hsync(hsync), .pad_en_n(pad_en_n),
    .pad_out(pad_out), .pos(pos), .pos_valid(pos_valid), .timeout(timeout),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus: hsync, generator or manual pad_out ----------------
  bit   hs_on = 0, gen_mode = 0;
  int   hper = 8, ph = 0, gen_p = 0, gcnt = 0, line_cnt = 0;
  int   fall_line = 1000, glitch_line = 1000, glit_rem = 0;
  logic gen_hs_prev = 0, hs_new;

  always @(posedge clk_sys) begin
    #2;
    // generator: line counter cleared by the window, compare lags hsync by a clock
    if (gen_mode) begin
      if (!pad_en_n) gcnt = 0;
      else if (hsync && !gen_hs_prev) gcnt++;
      pad_out = (gcnt < gen_p);
    end
    gen_hs_prev = hsync;
    if (hs_on) begin ph = (ph + 1) % hper; hs_new = (ph < hper / 2); end
    else begin ph = 0; hs_new = 0; end
    if (hs_new && !hsync) begin
      line_cnt++;
      if (!gen_mode && line_cnt == glitch_line) glit_rem = 2;
    end
    hsync = hs_new;
    if (!gen_mode) begin
      pad_out = !((line_cnt >= fall_line) || glit_rem > 0);
      if (glit_rem > 0) glit_rem--;
    end
  end

  // ---------------- model: works on raw pins, results appear one edge later -----
  bit         model_on = 0, m_tick;
  int         m_ph = 0, m_lines = 0, m_run = 0, m_first = 0;
  logic       m_hs_prev = 0;
  logic [7:0] e_pos = 0, s_pos = 0;
  logic       e_vld = 0, s_vld = 0, e_to = 0, s_to = 0, e_busy = 0, s_busy = 0;

  always @(posedge clk_sys) begin
    if (!reset_n) begin
      model_on = 1;
      e_pos = 0; s_pos = 0; e_vld = 0; s_vld = 0; e_to = 0; s_to = 0;
      e_busy = 0; s_busy = 0; m_ph = 0; m_lines = 0; m_run = 0; m_hs_prev = 0;
    end else begin
      e_pos = s_pos; e_vld = s_vld; e_to = s_to; e_busy = s_busy; s_vld = 0;
      m_tick = hsync && !m_hs_prev;
      m_hs_prev = hsync;
      if (m_ph == 0) begin
        if (pad_en_n) begin m_ph = 1; m_lines = 0; m_run = 0; end
      end else if (m_ph == 1) begin
        if (!pad_out) begin m_run++; if (m_run == 1) m_first = m_lines; end
        else m_run = 0;
        if (m_run >= ACC) begin
          s_pos = 8'(m_first); s_to = 0; s_vld = 1; m_ph = 2;
        end else if (!pad_en_n) begin
          s_pos = 8'(pad_out ? m_lines : m_first); s_to = 1; s_vld = 1; m_ph = 0;
        end else if (m_tick) begin
          if (m_lines >= 255) begin s_pos = 8'd255; s_to = 1; s_vld = 1; m_ph = 2; end
          else m_lines++;
        end
      end else begin
        if (!pad_en_n) m_ph = 0;
      end
      s_busy = (m_ph == 1);
    end
  end

  // ---------------- compare every cycle, tally captures ----------------
  int         valid_cnt = 0;
  logic [7:0] cap_pos = 0;
  logic       cap_to = 0;

  always @(negedge clk_sys) begin
    if (model_on) begin
      chk("pos", int'(pos), int'(e_pos));
      chk("pos_valid", int'(pos_valid), int'(e_vld));
      chk("timeout", int'(timeout), int'(e_to));
      chk("busy", int'(busy), int'(e_busy));
      if (pos_valid === 1'b1) begin
        valid_cnt++; cap_pos = pos; cap_to = timeout;
      end
    end
  end

  // ---------------- directed windows ----------------
  task automatic wait_lines(input int n);
    int budget = n * hper + 200;
    while (line_cnt < n && budget > 0) begin @(negedge clk_sys); budget--; end
    chk("lines_reached", line_cnt, n);
  endtask

  task automatic window(input bit gen, input int p, input int per, input int fl,
                        input int gl, input int lines, input int exp_pos,
                        input int exp_to, input string nm);
    int v0;
    @(negedge clk_sys);
    gen_mode = gen; gen_p = p; hper = per; fall_line = fl; glitch_line = gl;
    line_cnt = 0; v0 = valid_cnt;
    repeat (3) @(negedge clk_sys);
    pad_en_n = 1;
    repeat (4) @(negedge clk_sys);
    hs_on = 1;
    wait_lines(lines);
    hs_on = 0;
    repeat (2) @(negedge clk_sys);
    pad_en_n = 0;
    repeat (6) @(negedge clk_sys);
    chk({nm, "_pulses"}, valid_cnt - v0, 1);
    chk({nm, "_pos"}, int'(cap_pos), exp_pos);
    chk({nm, "_timeout"}, int'(cap_to), exp_to);
  endtask

  initial begin
    int v0;
    repeat (3) @(negedge clk_sys);
    chk("rst_pos", int'(pos), 0);
    chk("rst_valid", int'(pos_valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1;

    window(1, 114, 64, 1000, 1000, 260, 114, 0, "loop114");
    window(1, 0,   8,  1000, 1000, 20,  0,   0, "loop0");
    window(1, 255, 8,  1000, 1000, 270, 255, 0, "loop255");
    window(0, 0,   8,  1000, 1000, 40,  40,  1, "close40");
    window(0, 0,   8,  1000, 1000, 300, 255, 1, "sat");
    window(0, 0,   8,  78,   1000, 100, 77,  0, "tickfall77");
    window(0, 0,   8,  91,   31,   120, (ACC > 1) ? 90 : 30, 0, "glitch");

    // reset in the middle of a window: everything clears and nothing is captured
    @(negedge clk_sys);
    gen_mode = 0; fall_line = 1000; glitch_line = 1000; line_cnt = 0; v0 = valid_cnt;
    repeat (3) @(negedge clk_sys);
    pad_en_n = 1;
    repeat (4) @(negedge clk_sys);
    hs_on = 1;
    wait_lines(50);
    reset_n = 0; pad_en_n = 0; hs_on = 0;
    @(negedge clk_sys);
    chk("midrst_pos", int'(pos), 0);
    chk("midrst_valid", int'(pos_valid), 0);
    chk("midrst_timeout", int'(timeout), 0);
    chk("midrst_busy", int'(busy), 0);
    reset_n = 1;
    repeat (10) @(negedge clk_sys);
    chk("midrst_pulses", valid_cnt - v0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
